// File: rtl/boot_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : boot_loader_pkg                                                 |
// | Purpose  : Shared boot definitions: sequencer state encodings, the BIOS     |
// |            image length and opcode constants common to BIOS and decoder.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package boot_loader_pkg;

  // Boot sequencer states; encodings are visible to debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } boot_state_e;

  // Length of the BIOS image in 32-bit words.
  localparam int BIOS_WORDS = 109;

  // Opcode constants shared between the BIOS image builder and the decoder.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : boot_loader                                                     |
// | Purpose  : Copies BOOT_WORDS words from BIOS ROM address 0.. into          |
// |            instruction memory at DEST_BASE.., holding the CPU in reset     |
// |            until the last word is accepted; keeps a running checksum.      |
// | Ports    : clock, reset (sync, active-high), start (level-sampled)         |
// |            rom_addr / rom_data        - BIOS ROM read port                 |
// |            imem_we/addr/wdata/ready   - instruction-memory write port      |
// |            cpu_hold, busy, done       - boot status                        |
// |            checksum                   - mod-2^WORD_W sum of copied words   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int BOOT_WORDS = BIOS_WORDS,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEST_BASE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  input  logic              imem_ready,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(BOOT_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEST_BASE);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic [WORD_W-1:0] checksum_q, checksum_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      checksum_q   <= checksum_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    checksum_d   = checksum_q;
    case (state_q)
      // IDLE and DONE restart identically: a fresh image and a fresh checksum.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_FETCH;
          idx_d      = '0;
          checksum_d = '0;
        end
      end
      ST_FETCH: begin
        // rom_addr has been presenting idx for this whole cycle.
        imem_wdata_d = rom_data;
        imem_addr_d  = BASE_ADDR + idx_q;
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        if (imem_ready) begin
          checksum_d = checksum_q + imem_wdata_q;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output comes straight from a register or a decode of state_q.
  assign rom_addr   = idx_q;
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = (state_q != ST_DONE);
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);
  assign checksum   = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_boot_loader                                                  |
// | Purpose  : Self-checking bench for boot_loader (default image and a       |
// |            single-word image placed at the top of memory).                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset, start, imem_ready;
  logic [9:0]  rom_addr, imem_addr;
  logic [31:0] rom_data, imem_wdata, checksum;
  logic        imem_we, cpu_hold, busy, done;
  logic [31:0] rom_key;

  logic        s_start, s_ready;
  logic [9:0]  s_rom_addr, s_addr;
  logic [31:0] s_rom_data, s_wdata, s_sum;
  logic        s_we, s_hold, s_busy, s_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t sb[$];

  always #5 clk = ~clk;

  // ROM models: word i holds (i+1) ^ key, second ROM holds a distinct pattern.
  assign rom_data   = (32'(rom_addr) + 32'd1) ^ rom_key;
  assign s_rom_data = 32'hDEAD_0000 + 32'(s_rom_addr);

  boot_loader dut (
    .clock(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .checksum(checksum)
  );

  boot_loader #(.BOOT_WORDS(1), .WORD_W(32), .ADDR_W(10), .DEST_BASE(1023)) dut1 (
    .clock(clk), .reset(reset), .start(s_start),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .imem_ready(s_ready), .cpu_hold(s_hold), .busy(s_busy), .done(s_done),
    .checksum(s_sum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs set for the coming posedge: scores any
  // transfer that edge will perform, then advances to the next negedge.
  task automatic step();
    xfer_t e;
    if (imem_we && imem_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_image(input logic [31:0] key, output logic [31:0] sum);
    xfer_t e;
    sum = 32'd0;
    rom_key = key;
    for (int i = 0; i < 109; i++) begin
      e.addr = 10'(i);
      e.data = (32'(i) + 32'd1) ^ key;
      sum += e.data;
      sb.push_back(e);
    end
  endtask

  // One complete boot from IDLE/DONE. Optionally stalls the write of
  // stall_addr for stall_n cycles and pokes start while the copy runs.
  task automatic run_copy(input int stall_addr, input int stall_n, input bit poke,
                          output int cyc, output int wec);
    int left;
    logic [9:0]  ha;
    logic [31:0] hd;
    left = stall_n;
    wec  = 0;
    ha   = '0;
    hd   = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk("start_checksum", checksum, 32'd0);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    while (done !== 1'b1 && cyc < 1000) begin
      imem_ready = 1'b1;
      if (imem_we && imem_addr == 10'(stall_addr)) begin
        if (wec == 0) begin
          ha = imem_addr;
          hd = imem_wdata;
        end else begin
          chk("stall_addr_stable", 32'(imem_addr), 32'(ha));
          chk("stall_data_stable", imem_wdata, hd);
        end
        wec++;
        if (left > 0) begin
          imem_ready = 1'b0;
          left--;
        end
      end
      start = poke && (cyc % 7 == 3);
      if (cyc % 16 == 0) chk("copy_busy", 32'({cpu_hold, busy}), 32'd3);
      step();
      cyc++;
    end
    start = 1'b0;
    imem_ready = 1'b1;
    chk("end_done", 32'(done), 32'd1);
    chk("end_hold", 32'(cpu_hold), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int          cyc, wec;
    logic [31:0] sum;
    reset = 1'b1; start = 1'b0; imem_ready = 1'b1; rom_key = '0;
    s_start = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_flags", 32'({cpu_hold, busy, done}), 32'b100);
    chk("rst_checksum", checksum, 32'd0);
    repeat (3) step();
    chk("idle_no_autostart", 32'(busy), 32'd0);

    // 1: cold boot, ready tied high
    push_image(32'd0, sum);
    run_copy(-1, 0, 1'b0, cyc, wec);
    chk("t1_cycles", 32'(cyc), 32'd219);
    chk("t1_checksum", checksum, 32'd5995);
    repeat (2) step();
    chk("t1_checksum_held", checksum, 32'd5995);

    // 2: 3-cycle stall on word 5 (warm reboot from DONE)
    push_image(32'h0F0F_1234, sum);
    run_copy(5, 3, 1'b0, cyc, wec);
    chk("t2_we_cycles", 32'(wec), 32'd4);
    chk("t2_cycles", 32'(cyc), 32'd222);
    chk("t2_checksum", checksum, sum);

    // 4: start poked during FETCH/WRITE
    push_image(32'hA5A5_0000, sum);
    run_copy(-1, 0, 1'b1, cyc, wec);
    chk("t4_cycles", 32'(cyc), 32'd219);
    chk("t4_checksum", checksum, sum);

    // 5: warm reboot with the original image reproduces run 1
    push_image(32'd0, sum);
    run_copy(-1, 0, 1'b0, cyc, wec);
    chk("t5_cycles", 32'(cyc), 32'd219);
    chk("t5_checksum", checksum, 32'd5995);

    // 3: reset during WRITE of word 40, then a full restart
    push_image(32'h1111_0000, sum);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(imem_we && imem_addr == 10'd40) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("t3_reached_w40", 32'(imem_we && imem_addr == 10'd40), 32'd1);
    imem_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    imem_ready = 1'b1;
    chk("t3_abort_we", 32'(imem_we), 32'd0);
    chk("t3_abort_flags", 32'({cpu_hold, busy, done}), 32'b100);
    chk("t3_abort_checksum", checksum, 32'd0);
    sb.delete();
    repeat (2) step();
    chk("t3_stays_idle", 32'({cpu_hold, busy, done}), 32'b100);
    push_image(32'h1111_0000, sum);
    run_copy(-1, 0, 1'b0, cyc, wec);
    chk("t3_cycles", 32'(cyc), 32'd219);
    chk("t3_checksum", checksum, sum);

    // 6: single-word image at the top of the address space
    chk("t6_idle", 32'({s_hold, s_busy, s_done}), 32'b100);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("t6_fetch", 32'({s_busy, s_we}), 32'b10);
    chk("t6_rom_addr", 32'(s_rom_addr), 32'd0);
    step();
    chk("t6_we", 32'(s_we), 32'd1);
    chk("t6_addr", 32'(s_addr), 32'd1023);
    chk("t6_data", s_wdata, 32'hDEAD_0000);
    step();
    chk("t6_done", 32'({s_hold, s_busy, s_done}), 32'b001);
    chk("t6_checksum", s_sum, 32'hDEAD_0000);
    repeat (3) step();
    chk("t6_no_wrap_we", 32'(s_we), 32'd0);
    chk("t6_rom_addr_end", 32'(s_rom_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
